// File: rtl/leaf_egress_pkg.sv
// Shared definitions for the leaf egress scheduler: FSM state encoding,
// packet valid-bit position and the round-robin index helper.
package leaf_egress_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int PACKET_BITS_DEF = 97;
    localparam int PKT_VALID_BIT   = PACKET_BITS_DEF - 1;

    // Index that follows idx in a ring of n entries.
    function automatic int rr_next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr_i (wrapping)
// wins; next_ptr_o is the slot after the winner, for use on acceptance.
module rr_arbiter
    import leaf_egress_pkg::*;
#(
    parameter int N  = 7,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] next_ptr_o,
    output logic          any_o
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Scan the ring starting at the pointer and keep the first hit.
    always_comb begin
        grant_o    = '0;
        next_ptr_o = ptr_i;
        any_o      = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!any_o && req_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                next_ptr_o   = PW'(rr_next_idx(int'(idx), N));
            end
        end
    end

endmodule

// File: rtl/leaf_egress_scheduler.sv
// Leaf egress scheduler: shares stream_out between freespace-update
// requesters (fixed priority, always preferred) and output-port FIFOs
// (round-robin). A resend from the switch freezes the current packet.
// Optional macro LEAF_EGRESS_FS_BURST_LIMIT_EN bounds consecutive
// freespace grants to FS_BURST_MAX while data is waiting.
module leaf_egress_scheduler
    import leaf_egress_pkg::*;
#(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_OUT_PORTS = 7,
    parameter int FS_BURST_MAX  = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_IN_PORTS-1:0]               fs_req,
    input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]   fs_pkt,
    output logic [NUM_IN_PORTS-1:0]               fs_ack,
    input  logic [NUM_OUT_PORTS-1:0]              out_empty,
    input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0]  out_pkt,
    output logic [NUM_OUT_PORTS-1:0]              out_rd_en,
    input  logic                                  resend,
    output logic [PACKET_BITS-1:0]                stream_out,
    output logic                                  busy
);

    localparam int PW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

    // A burst limit of zero would starve freespace entirely; refuse it.
    if (FS_BURST_MAX < 1) begin : g_bad_fs_burst_max
        $error("FS_BURST_MAX must be at least 1");
    end

    state_e                   state_q, state_d;
    logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [PACKET_BITS-1:0]   stream_q, stream_d;

    logic [NUM_IN_PORTS-1:0]  fs_pick_oh;
    logic                     any_fs;
    logic [NUM_OUT_PORTS-1:0] data_grant_oh;
    logic [PW-1:0]            rr_next;
    logic                     any_data;
    logic [PACKET_BITS-1:0]   fs_sel, data_sel;
    logic                     eval_en, fs_win, data_win, force_data;

    rr_arbiter #(
        .N  (NUM_OUT_PORTS),
        .PW (PW)
    ) u_rr (
        .req_i      (~out_empty),
        .ptr_i      (rr_ptr_q),
        .grant_o    (data_grant_oh),
        .next_ptr_o (rr_next),
        .any_o      (any_data)
    );

    // Fixed priority among freespace requesters: lowest index wins.
    always_comb begin
        fs_pick_oh = '0;
        any_fs     = 1'b0;
        for (int i = 0; i < NUM_IN_PORTS; i++) begin
            if (!any_fs && fs_req[i]) begin
                fs_pick_oh[i] = 1'b1;
                any_fs        = 1'b1;
            end
        end
    end

    // One-hot AND-OR muxes selecting the granted packet slices.
    always_comb begin
        fs_sel   = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_IN_PORTS; i++) begin
            if (fs_pick_oh[i]) begin
                fs_sel = fs_sel | fs_pkt[i*PACKET_BITS +: PACKET_BITS];
            end
        end
        for (int j = 0; j < NUM_OUT_PORTS; j++) begin
            if (data_grant_oh[j]) begin
                data_sel = data_sel | out_pkt[j*PACKET_BITS +: PACKET_BITS];
            end
        end
    end

    // Resend only matters while a packet is actually on the link.
    assign eval_en   = !reset && ((state_q == ST_IDLE) || !resend);
    assign fs_win    = eval_en && any_fs && !force_data;
    assign data_win  = eval_en && any_data && !fs_win;
    assign fs_ack    = fs_win   ? fs_pick_oh    : '0;
    assign out_rd_en = data_win ? data_grant_oh : '0;

    // Next-state: load a granted packet, go idle with zero, or freeze on resend.
    always_comb begin
        state_d  = state_q;
        stream_d = stream_q;
        rr_ptr_d = rr_ptr_q;
        if (fs_win) begin
            stream_d = fs_sel;
            state_d  = ST_SEND;
        end else if (data_win) begin
            stream_d = data_sel;
            rr_ptr_d = rr_next;
            state_d  = ST_SEND;
        end else if (eval_en) begin
            stream_d = '0;
            state_d  = ST_IDLE;
        end else if (state_q != ST_IDLE) begin
            state_d  = ST_HOLD;
        end
    end

    // Registered egress, FSM and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            stream_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            stream_q <= stream_d;
        end
    end

`ifdef LEAF_EGRESS_FS_BURST_LIMIT_EN
    localparam int RUN_W = $clog2(FS_BURST_MAX + 1);

    logic [RUN_W-1:0] fs_run_q, fs_run_d;

    assign force_data = any_data && (fs_run_q == RUN_W'(FS_BURST_MAX));

    // Count freespace grants made while data waits; any data grant or empty FIFOs restart it.
    always_comb begin
        fs_run_d = fs_run_q;
        if (!any_data || data_win) begin
            fs_run_d = '0;
        end else if (fs_win) begin
            fs_run_d = fs_run_q + RUN_W'(1);
        end
    end

    // Burst counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_run_q <= '0;
        end else begin
            fs_run_q <= fs_run_d;
        end
    end
`else
    assign force_data = 1'b0;
`endif

    assign stream_out = stream_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_leaf_egress_scheduler.sv
// Directed bench for leaf_egress_scheduler with hand-computed expectations.
module tb_leaf_egress_scheduler;
    import leaf_egress_pkg::*;

    localparam int PB = 97;
    localparam int NI = 7;
    localparam int NO = 7;

    logic               clk = 1'b0;
    logic               reset;
    logic [NI-1:0]      fs_req;
    logic [PB*NI-1:0]   fs_pkt;
    logic [NI-1:0]      fs_ack;
    logic [NO-1:0]      out_empty;
    logic [PB*NO-1:0]   out_pkt;
    logic [NO-1:0]      out_rd_en;
    logic               resend;
    logic [PB-1:0]      stream_out;
    logic               busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    leaf_egress_scheduler #(
        .PACKET_BITS   (PB),
        .NUM_IN_PORTS  (NI),
        .NUM_OUT_PORTS (NO),
        .FS_BURST_MAX  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fs_req     (fs_req),
        .fs_pkt     (fs_pkt),
        .fs_ack     (fs_ack),
        .out_empty  (out_empty),
        .out_pkt    (out_pkt),
        .out_rd_en  (out_rd_en),
        .resend     (resend),
        .stream_out (stream_out),
        .busy       (busy)
    );

    function automatic logic [PB-1:0] mkpkt(input logic [15:0] tag);
        logic [PB-1:0] p;
        p = '0;
        p[PKT_VALID_BIT] = 1'b1;
        p[15:0] = tag;
        return p;
    endfunction

    function automatic logic [PB-1:0] fsp(input int i);
        return mkpkt(16'h0100 + 16'(i));
    endfunction

    function automatic logic [PB-1:0] dp(input int j);
        return mkpkt(16'h0200 + 16'(j));
    endfunction

    task automatic check(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [PB-1:0] prev_exp;
    logic          data_turn;

    initial begin
        for (int i = 0; i < NI; i++) fs_pkt[i*PB +: PB] = fsp(i);
        for (int j = 0; j < NO; j++) out_pkt[j*PB +: PB] = dp(j);
        reset = 1'b1; resend = 1'b0;
        fs_req = 7'b0000001; out_empty = 7'b0111111;
        tick(); tick();
        check("rst_fs_ack", PB'(fs_ack), '0);
        check("rst_rd_en", PB'(out_rd_en), '0);
        check("rst_stream", stream_out, '0);
        check("rst_busy", PB'(busy), '0);
        fs_req = '0; out_empty = '1; reset = 1'b0;
        tick();

        // Round-robin over ports 0 and 2, FIFOs never drain.
        out_empty = 7'b1111010; #1;
        check("rr_g0", PB'(out_rd_en), PB'(7'b0000001));
        check("rr_idle_stream", stream_out, '0);
        check("rr_idle_busy", PB'(busy), '0);
        tick();
        check("rr_s0", stream_out, dp(0));
        check("rr_busy", PB'(busy), PB'(1'b1));
        check("rr_g1", PB'(out_rd_en), PB'(7'b0000100));
        tick();
        check("rr_s1", stream_out, dp(2));
        check("rr_g2", PB'(out_rd_en), PB'(7'b0000001));
        tick();
        check("rr_s2", stream_out, dp(0));
        check("rr_g3", PB'(out_rd_en), PB'(7'b0000100));
        tick(); out_empty = '1; #1;
        check("rr_s3", stream_out, dp(2));
        check("rr_none", PB'(out_rd_en), '0);
        tick();
        check("rr_s_end", stream_out, '0);
        check("rr_busy_end", PB'(busy), '0);

        // Freespace beats data; data port 3 served third.
        fs_req = 7'b0000110; out_empty = 7'b1110111; #1;
        check("pri_ack1", PB'(fs_ack), PB'(7'b0000010));
        check("pri_rd1", PB'(out_rd_en), '0);
        tick(); fs_req = 7'b0000100; #1;
        check("pri_s1", stream_out, fsp(1));
        check("pri_ack2", PB'(fs_ack), PB'(7'b0000100));
        check("pri_rd2", PB'(out_rd_en), '0);
        tick(); fs_req = '0; #1;
        check("pri_s2", stream_out, fsp(2));
        check("pri_ack3", PB'(fs_ack), '0);
        check("pri_rd3", PB'(out_rd_en), PB'(7'b0001000));
        tick(); out_empty = '1; #1;
        check("pri_s3", stream_out, dp(3));
        tick();
        check("pri_s_end", stream_out, '0);

        // Resend for three cycles freezes packet from port 4.
        out_empty = 7'b1101111; #1;
        check("rs_rd", PB'(out_rd_en), PB'(7'b0010000));
        tick(); out_empty = '1; resend = 1'b1; fs_req = 7'b0000001; #1;
        check("rs_c1_s", stream_out, dp(4));
        check("rs_c1_ack", PB'(fs_ack), '0);
        tick();
        check("rs_c2_s", stream_out, dp(4));
        check("rs_c2_ack", PB'(fs_ack), '0);
        check("rs_c2_busy", PB'(busy), PB'(1'b1));
        tick();
        check("rs_c3_s", stream_out, dp(4));
        check("rs_c3_ack", PB'(fs_ack), '0);
        tick(); resend = 1'b0; #1;
        check("rs_c4_s", stream_out, dp(4));
        check("rs_c4_ack", PB'(fs_ack), PB'(7'b0000001));
        tick(); fs_req = '0; #1;
        check("rs_next_s", stream_out, fsp(0));
        check("rs_next_ack", PB'(fs_ack), '0);
        tick();
        check("rs_end_s", stream_out, '0);
        check("rs_end_busy", PB'(busy), '0);

        // Reset while holding port 1's packet.
        out_empty = 7'b1111101; #1;
        check("rh_rd", PB'(out_rd_en), PB'(7'b0000010));
        tick(); out_empty = '1; resend = 1'b1; #1;
        check("rh_s1", stream_out, dp(1));
        tick();
        check("rh_hold_s", stream_out, dp(1));
        check("rh_hold_busy", PB'(busy), PB'(1'b1));
        reset = 1'b1;
        tick(); reset = 1'b0; resend = 1'b0;
        check("rh_rst_s", stream_out, '0);
        check("rh_rst_busy", PB'(busy), '0);
        out_empty = 7'b1011110; #1;
        check("rh_ptr0", PB'(out_rd_en), PB'(7'b0000001));
        tick(); out_empty = '1; #1;
        check("rh_s0", stream_out, dp(0));
        tick();

        // Resend toggling while idle changes nothing.
        for (int k = 0; k < 4; k++) begin
            resend = ~resend;
            tick();
            check("idle_rs_s", stream_out, '0);
            check("idle_rs_busy", PB'(busy), '0);
        end
        resend = 1'b1; out_empty = 7'b0111111; #1;
        check("idle_rs_grant", PB'(out_rd_en), PB'(7'b1000000));
        tick(); resend = 1'b0; out_empty = '1; #1;
        check("idle_rs_s6", stream_out, dp(6));
        tick();
        check("idle_rs_end", stream_out, '0);

        // Constant freespace request against FIFO 5.
        fs_req = 7'b0000001; out_empty = 7'b1011111; #1;
        prev_exp = '0;
        for (int k = 0; k < 10; k++) begin
`ifdef LEAF_EGRESS_FS_BURST_LIMIT_EN
            data_turn = ((k % 5) == 4);
`else
            data_turn = 1'b0;
`endif
            check("burst_ack", PB'(fs_ack), data_turn ? '0 : PB'(7'b0000001));
            check("burst_rd", PB'(out_rd_en), data_turn ? PB'(7'b0100000) : '0);
            if (k > 0) check("burst_s", stream_out, prev_exp);
            prev_exp = data_turn ? dp(5) : fsp(0);
            tick();
        end
        fs_req = '0; out_empty = '1;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
